// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: serializes single-word accesses from the CPU (port 0)
// and a DMA master (port 1) onto one memory port, round-robin on ties.
module mem_arbiter #(
   parameter int LAT = 1
) (
   input  logic        clock,
   input  logic        reset_L,
   input  logic        req0,
   input  logic        req1,
   input  logic        we0,
   input  logic        we1,
   input  logic [15:0] addr0,
   input  logic [15:0] addr1,
   input  logic [15:0] wdata0,
   input  logic [15:0] wdata1,
   output logic        gnt0,
   output logic        gnt1,
   output logic        done0,
   output logic        done1,
   output logic [15:0] rdata0,
   output logic [15:0] rdata1,
   output logic        mem_re,
   output logic        mem_we,
   output logic [15:0] mem_addr,
   output logic [15:0] mem_wdata,
   input  logic [15:0] mem_rdata
);

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   localparam logic [3:0] CNT_READ = 4'(LAT - 1);

   state_t      state_reg, state_next;
   logic        owner_reg, owner_next;
   logic        last_reg, last_next;
   logic [3:0]  cnt_reg, cnt_next;
   logic        we_reg, we_next;
   logic [15:0] addr_reg, addr_next;
   logic [15:0] wdata_reg, wdata_next;
   logic [15:0] rdata0_reg, rdata0_next;
   logic [15:0] rdata1_reg, rdata1_next;
   logic        winner;

   always_ff @(posedge clock or negedge reset_L) begin
      if (!reset_L) begin
         state_reg  <= IDLE;
         owner_reg  <= 1'b0;
         last_reg   <= 1'b1;
         cnt_reg    <= 4'd0;
         we_reg     <= 1'b0;
         addr_reg   <= 16'h0000;
         wdata_reg  <= 16'h0000;
         rdata0_reg <= 16'h0000;
         rdata1_reg <= 16'h0000;
      end else begin
         state_reg  <= state_next;
         owner_reg  <= owner_next;
         last_reg   <= last_next;
         cnt_reg    <= cnt_next;
         we_reg     <= we_next;
         addr_reg   <= addr_next;
         wdata_reg  <= wdata_next;
         rdata0_reg <= rdata0_next;
         rdata1_reg <= rdata1_next;
      end
   end

   // A lone requester wins; on a tie the port that did not own the last grant wins.
   always_comb begin
      winner = 1'b0;
      if (req0 && req1) begin
         winner = ~last_reg;
      end else if (req1) begin
         winner = 1'b1;
      end
   end

   always_comb begin
      state_next  = state_reg;
      owner_next  = owner_reg;
      last_next   = last_reg;
      cnt_next    = cnt_reg;
      we_next     = we_reg;
      addr_next   = addr_reg;
      wdata_next  = wdata_reg;
      rdata0_next = rdata0_reg;
      rdata1_next = rdata1_reg;
      case (state_reg)
         IDLE: begin
            if (req0 || req1) begin
               state_next = ACCESS;
               owner_next = winner;
               last_next  = winner;
               we_next    = winner ? we1 : we0;
               addr_next  = winner ? addr1 : addr0;
               wdata_next = winner ? wdata1 : wdata0;
               cnt_next   = (winner ? we1 : we0) ? 4'd0 : CNT_READ;
            end
         end
         ACCESS: begin
            if (cnt_reg == 4'd0) begin
               state_next = RESP;
               if (!we_reg) begin
                  if (owner_reg) begin
                     rdata1_next = mem_rdata;
                  end else begin
                     rdata0_next = mem_rdata;
                  end
               end
            end else begin
               cnt_next = cnt_reg - 4'd1;
            end
         end
         RESP: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Every output is a decode of registered state only.
   assign gnt0      = (state_reg != IDLE) && !owner_reg;
   assign gnt1      = (state_reg != IDLE) && owner_reg;
   assign done0     = (state_reg == RESP) && !owner_reg;
   assign done1     = (state_reg == RESP) && owner_reg;
   assign mem_re    = (state_reg == ACCESS) && !we_reg;
   assign mem_we    = (state_reg == ACCESS) && we_reg;
   assign mem_addr  = addr_reg;
   assign mem_wdata = wdata_reg;
   assign rdata0    = rdata0_reg;
   assign rdata1    = rdata1_reg;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port memory arbiter that shares the single RISC240 memory port between the CPU (port 0, driven by the MAR/MDR path with RE/WE strobes) and a secondary master (port 1, DMA/program loader). It serializes single-word accesses, grants in round-robin order when both ports request, holds reads open for a parameterized memory latency, and returns read data and a one-cycle completion pulse to the owning requester. It sits between the CPU datapath and the memory module.

## Interface
- `LAT`, default 1: memory read latency in cycles. Legal range 1..15.
- `clock`  in  1  system clock; all state changes on the rising edge.
- `reset_L`  in  1  asynchronous, active-low reset.
- `req0`, `req1`  in  1  access request from port 0 (CPU) / port 1 (DMA); held until `done` is seen.
- `we0`, `we1`  in  1  1 = write, 0 = read; valid while `req` is high.
- `addr0`, `addr1`  in  16  word address.
- `wdata0`, `wdata1`  in  16  write data.
- `gnt0`, `gnt1`  out  1  port owns the memory (ACCESS or RESP state).
- `done0`, `done1`  out  1  one-cycle completion pulse.
- `rdata0`, `rdata1`  out  16  read data; valid when `done` is high and held until the next read completes on that port.
- `mem_re`  out  1  memory read strobe.
- `mem_we`  out  1  memory write strobe.
- `mem_addr`  out  16  memory address.
- `mem_wdata`  out  16  memory write data.
- `mem_rdata`  in  16  memory read data, valid at the edge ending the last read cycle.

## Operation
- FSM states:
  - IDLE: no owner.
  - ACCESS: strobe active; a 4-bit counter `cnt` tracks cycles.
  - RESP: `done` of the owner is high.
- IDLE, at a rising edge:
  - If `req0` or `req1` is high, choose a winner, latch `we`, `addr`, `wdata` and the owner ID, load `cnt` with LAT-1 for a read or 0 for a write, and go to ACCESS.
  - Otherwise stay in IDLE.
- Arbitration:
  - If only one port requests, it wins.
  - If both request, the winner is the port other than `last`, the owner of the most recent grant.
  - `last` updates on every grant. It resets to 1, so port 0 wins the first tie.
- ACCESS:
  - `mem_addr` and `mem_wdata` come from the latched values.
  - `mem_re` = !latched_we; `mem_we` = latched_we.
  - If `cnt` is 0 at the edge: capture `mem_rdata` into the owner's `rdata` register (reads only) and go to RESP.
  - Otherwise decrement `cnt`.
- RESP: the owner's `done` is 1 and both strobes are 0. Go to IDLE unconditionally.
- `req` is ignored during ACCESS and RESP. The non-owner's request simply waits.
- Requester rule: the requester must drop `req` by the edge that ends RESP unless it wants a new access. A `req` still high in IDLE is treated as a new request.
- All outputs are driven from registered state. No combinational path runs from `req*` or `mem_rdata` to any output.
- Reset, asynchronous: registers and outputs go to these values immediately, even mid-access, and any in-flight access is abandoned.
  - State = IDLE, `last` = 1, `cnt` = 0.
  - `gnt*`, `done*`, `mem_re`, `mem_we` = 0.
  - `mem_addr`, `mem_wdata`, `rdata0`, `rdata1` = 16'h0000.

## Timing
- Read: `req` is sampled high at edge E0 in IDLE.
  - `gnt` and `mem_re` are high from E0 to E0+LAT, i.e. LAT cycles.
  - `mem_rdata` is sampled at E0+LAT.
  - `done` is high from E0+LAT to E0+LAT+1.
  - IDLE resumes at E0+LAT+1. The earliest next grant edge is E0+LAT+2.
- Write: `mem_we` is high for exactly one cycle, E0 to E0+1. `done` is high from E0+1 to E0+2. The next grant edge is E0+3.
- `gnt` covers the ACCESS and RESP cycles. `done` and `gnt` of the non-owner stay 0 throughout.
- `mem_re` and `mem_we` are never high together, and never high outside ACCESS.
- Throughput: one read per LAT+2 cycles; one write per 3 cycles.

## Test plan
- Single read on port 0, LAT=2, `addr0`=16'h0040, memory returns 16'hBEEF:
  - `mem_re` is high for 2 cycles with `mem_addr`=16'h0040.
  - `done0` pulses one cycle later with `rdata0`=16'hBEEF.
  - `gnt1` and `done1` stay 0.
- Single write on port 1, `addr1`=16'h0100, `wdata1`=16'h1234:
  - `mem_we` is high exactly one cycle carrying those values.
  - `done1` pulses the next cycle.
  - `mem_re` stays 0.
- Both ports hold `req` high continuously after reset, for 4 accesses:
  - Grant order is 0, 1, 0, 1.
  - Each `done` matches its owner; the strobes never overlap.
- Port 0 requests alone three times back-to-back (dropping `req` at `done`, re-raising it in IDLE):
  - Port 0 is granted each time; `last` stays 0.
  - A `req1` arriving during port 0's ACCESS is granted next.
- `reset_L` is pulled low mid-ACCESS of a LAT=3 read:
  - `mem_re`, `gnt*` and `done*` go to 0 within the same cycle, without waiting for a clock edge.
  - After release, the first request gets a normal full-latency access.
- Read on port 1 (16'hAAAA), then read on port 0 (16'h5555):
  - `rdata1` holds 16'hAAAA unchanged through port 0's access.
  - `rdata0` becomes 16'h5555.
